// File: rtl/slv_guard_wd_pkg.sv
// Shared types for the slave-guard watchdog: fault causes, per-port
// supervisor states and the outstanding-transaction counter width.
package slv_guard_wd_pkg;

  // Fault cause; on same-cycle events the numerically highest code is kept.
  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_AW    = 3'd1,
    CAUSE_W     = 3'd2,
    CAUSE_B     = 3'd3,
    CAUSE_AR    = 3'd4,
    CAUSE_R     = 3'd5,
    CAUSE_PROTO = 3'd6,
    CAUSE_OVF   = 3'd7
  } cause_e;

  // Per-port supervisor states.
  typedef enum logic [2:0] {
    ST_MON      = 3'd0,
    ST_FAULT    = 3'd1,
    ST_RST_REQ  = 3'd2,
    ST_RST_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } wd_state_e;

  // Width needed to count 0..max_txns outstanding transactions.
  function automatic int pend_width(input int max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage

// File: rtl/slv_guard_wd_chan.sv
// One monitored subordinate port: pending-transaction counters, five
// stall/latency timers, fault classification and the reset-request FSM.
module slv_guard_wd_chan
  import slv_guard_wd_pkg::*;
#(
  parameter int CntWidth = 10,
  parameter int MaxTxns  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                guard_ena_i,
  input  logic [1:0]          aw_hs_i,
  input  logic [2:0]          w_hs_i,
  input  logic [1:0]          b_hs_i,
  input  logic [1:0]          ar_hs_i,
  input  logic [2:0]          r_hs_i,
  input  logic [CntWidth-1:0] budget_aw_i,
  input  logic [CntWidth-1:0] budget_w_i,
  input  logic [CntWidth-1:0] budget_b_i,
  input  logic [CntWidth-1:0] budget_ar_i,
  input  logic [CntWidth-1:0] budget_r_i,
  input  logic                clr_i,
  input  logic                rst_stat_i,
  output logic                timeout_o,
  output cause_e              cause_o,
  output logic                rst_req_o
);

  localparam int PW = pend_width(MaxTxns);
  localparam logic [PW-1:0]       PEND_MAX  = PW'(MaxTxns);
  localparam logic [PW-1:0]       PEND_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]       PEND_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] TMR_ZERO  = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] TMR_ONE   = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] TMR_SAT   = {CntWidth{1'b1}};

  // Pending counters: index 0 = AW awaiting W last, 1 = awaiting B, 2 = AR awaiting R last.
  // Timers: index 0..4 = AW, W, B, AR, R.
  wd_state_e           r_state;
  wd_state_e           w_state_nxt;
  cause_e              r_cause;
  cause_e              w_cause_nxt;
  cause_e              w_cause_evt;
  logic                r_timeout;
  logic                r_rst_req;
  logic [PW-1:0]       r_pend     [3];
  logic [PW-1:0]       w_pend_nxt [3];
  logic [CntWidth-1:0] r_tmr      [5];
  logic [CntWidth-1:0] w_tmr_nxt  [5];
  logic [CntWidth-1:0] w_budget   [5];
  logic [2:0]          w_inc;
  logic [2:0]          w_dec;
  logic [4:0]          w_run;
  logic [4:0]          w_hit;
  logic [4:0]          w_tmr_off;
  logic                w_aw_hs, w_w_hs, w_wl_hs, w_b_hs, w_ar_hs, w_r_hs, w_rl_hs;
  logic                w_proto;
  logic                w_ovf;
  logic                w_clr_cnt;

  assign w_aw_hs = aw_hs_i[1] & aw_hs_i[0];
  assign w_w_hs  = w_hs_i[2] & w_hs_i[1];
  assign w_wl_hs = w_w_hs & w_hs_i[0];
  assign w_b_hs  = b_hs_i[1] & b_hs_i[0];
  assign w_ar_hs = ar_hs_i[1] & ar_hs_i[0];
  assign w_r_hs  = r_hs_i[2] & r_hs_i[1];
  assign w_rl_hs = w_r_hs & r_hs_i[0];

  assign w_inc = {w_ar_hs, w_wl_hs, w_aw_hs};
  assign w_dec = {w_rl_hs, w_b_hs,  w_wl_hs};

  assign w_budget[0] = budget_aw_i;
  assign w_budget[1] = budget_w_i;
  assign w_budget[2] = budget_b_i;
  assign w_budget[3] = budget_ar_i;
  assign w_budget[4] = budget_r_i;

  // Address stalls count while valid waits on ready; data/response latency
  // counts while something is outstanding and no beat arrives.
  assign w_run[0] = aw_hs_i[1] & ~aw_hs_i[0];
  assign w_run[1] = (r_pend[0] != PEND_ZERO) & ~w_w_hs;
  assign w_run[2] = (r_pend[1] != PEND_ZERO) & ~w_b_hs;
  assign w_run[3] = ar_hs_i[1] & ~ar_hs_i[0];
  assign w_run[4] = (r_pend[2] != PEND_ZERO) & ~w_r_hs;

  // A response beat arriving with nothing outstanding is a protocol error;
  // a same-cycle address handshake legitimises a W/R last.
  assign w_proto = (w_wl_hs & (r_pend[0] == PEND_ZERO) & ~w_aw_hs)
                 | (w_b_hs  & (r_pend[1] == PEND_ZERO))
                 | (w_rl_hs & (r_pend[2] == PEND_ZERO) & ~w_ar_hs);

  assign w_clr_cnt = (r_state == ST_RST_WAIT) & ~rst_stat_i;

  // Timer budget hits, overflow detection and per-counter next values.
  always_comb begin
    w_hit     = 5'b00000;
    w_tmr_off = 5'b00000;
    w_ovf     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w_hit[k]     = w_run[k] & (w_budget[k] != TMR_ZERO) & (r_tmr[k] == w_budget[k]);
      w_tmr_off[k] = ~guard_ena_i | (w_budget[k] == TMR_ZERO);
      if (!w_run[k]) begin
        w_tmr_nxt[k] = TMR_ZERO;
      end else if (r_tmr[k] == TMR_SAT) begin
        w_tmr_nxt[k] = TMR_SAT;
      end else begin
        w_tmr_nxt[k] = r_tmr[k] + TMR_ONE;
      end
    end
    for (int i = 0; i < 3; i++) begin
      w_ovf = w_ovf | (w_inc[i] & ~w_dec[i] & (r_pend[i] == PEND_MAX));
      if (w_inc[i] && !w_dec[i] && (r_pend[i] != PEND_MAX)) begin
        w_pend_nxt[i] = r_pend[i] + PEND_ONE;
      end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != PEND_ZERO)) begin
        w_pend_nxt[i] = r_pend[i] - PEND_ONE;
      end else begin
        w_pend_nxt[i] = r_pend[i];
      end
    end
  end

  // Highest-coded event of this cycle becomes the candidate cause.
  always_comb begin
    w_cause_evt = CAUSE_NONE;
    if (w_ovf) begin
      w_cause_evt = CAUSE_OVF;
    end else if (w_proto) begin
      w_cause_evt = CAUSE_PROTO;
    end else if (w_hit[4]) begin
      w_cause_evt = CAUSE_R;
    end else if (w_hit[3]) begin
      w_cause_evt = CAUSE_AR;
    end else if (w_hit[2]) begin
      w_cause_evt = CAUSE_B;
    end else if (w_hit[1]) begin
      w_cause_evt = CAUSE_W;
    end else if (w_hit[0]) begin
      w_cause_evt = CAUSE_AW;
    end else begin
      w_cause_evt = CAUSE_NONE;
    end
  end

  // Supervisor next state: fault latch, reset handshake, software release.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_MON: begin
        if (guard_ena_i && (w_cause_evt != CAUSE_NONE)) begin
          w_state_nxt = ST_FAULT;
          w_cause_nxt = w_cause_evt;
        end else begin
          w_state_nxt = ST_MON;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_RST_REQ;
      end
      ST_RST_REQ: begin
        if (rst_stat_i) begin
          w_state_nxt = ST_RST_WAIT;
        end else begin
          w_state_nxt = ST_RST_REQ;
        end
      end
      ST_RST_WAIT: begin
        if (!rst_stat_i) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_RST_WAIT;
        end
      end
      ST_HALT: begin
        if (clr_i) begin
          w_state_nxt = ST_MON;
          w_cause_nxt = CAUSE_NONE;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt = ST_MON;
        w_cause_nxt = CAUSE_NONE;
      end
    endcase
  end

  // State, registered outputs, counters (frozen outside MON) and timers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_MON;
      r_cause   <= CAUSE_NONE;
      r_timeout <= 1'b0;
      r_rst_req <= 1'b0;
      for (int i = 0; i < 3; i++) r_pend[i] <= PEND_ZERO;
      for (int k = 0; k < 5; k++) r_tmr[k] <= TMR_ZERO;
    end else begin
      r_state   <= w_state_nxt;
      r_cause   <= w_cause_nxt;
      r_timeout <= (w_state_nxt != ST_MON);
      r_rst_req <= (w_state_nxt == ST_RST_REQ);
      for (int i = 0; i < 3; i++) begin
        if (w_clr_cnt) begin
          r_pend[i] <= PEND_ZERO;
        end else if (r_state == ST_MON) begin
          r_pend[i] <= w_pend_nxt[i];
        end else begin
          r_pend[i] <= r_pend[i];
        end
      end
      for (int k = 0; k < 5; k++) begin
        if (w_clr_cnt || w_tmr_off[k]) begin
          r_tmr[k] <= TMR_ZERO;
        end else if (r_state == ST_MON) begin
          r_tmr[k] <= w_tmr_nxt[k];
        end else begin
          r_tmr[k] <= r_tmr[k];
        end
      end
    end
  end

  assign timeout_o = r_timeout;
  assign cause_o   = r_cause;
  assign rst_req_o = r_rst_req;

endmodule

// File: rtl/slv_guard_watchdog.sv
// Per-subordinate AXI watchdog: one independent channel monitor per port,
// with a single interrupt summarising all latched faults.
module slv_guard_watchdog
  import slv_guard_wd_pkg::*;
#(
  parameter int NumSub   = 2,
  parameter int CntWidth = 10,
  parameter int MaxTxns  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  guard_ena_i,
  input  logic [NumSub*2-1:0]   aw_hs_i,
  input  logic [NumSub*3-1:0]   w_hs_i,
  input  logic [NumSub*2-1:0]   b_hs_i,
  input  logic [NumSub*2-1:0]   ar_hs_i,
  input  logic [NumSub*3-1:0]   r_hs_i,
  input  logic [CntWidth-1:0]   budget_aw_i,
  input  logic [CntWidth-1:0]   budget_w_i,
  input  logic [CntWidth-1:0]   budget_b_i,
  input  logic [CntWidth-1:0]   budget_ar_i,
  input  logic [CntWidth-1:0]   budget_r_i,
  input  logic [NumSub-1:0]     clr_i,
  input  logic [NumSub-1:0]     rst_stat_i,
  output logic [NumSub-1:0]     timeout_o,
  output logic [NumSub*3-1:0]   cause_o,
  output logic [NumSub-1:0]     rst_req_o,
  output logic                  irq_o
);

  cause_e w_cause [NumSub];

  for (genvar g = 0; g < NumSub; g++) begin : g_port
    slv_guard_wd_chan #(
      .CntWidth (CntWidth),
      .MaxTxns  (MaxTxns)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .guard_ena_i (guard_ena_i),
      .aw_hs_i     (aw_hs_i[g*2 +: 2]),
      .w_hs_i      (w_hs_i[g*3 +: 3]),
      .b_hs_i      (b_hs_i[g*2 +: 2]),
      .ar_hs_i     (ar_hs_i[g*2 +: 2]),
      .r_hs_i      (r_hs_i[g*3 +: 3]),
      .budget_aw_i (budget_aw_i),
      .budget_w_i  (budget_w_i),
      .budget_b_i  (budget_b_i),
      .budget_ar_i (budget_ar_i),
      .budget_r_i  (budget_r_i),
      .clr_i       (clr_i[g]),
      .rst_stat_i  (rst_stat_i[g]),
      .timeout_o   (timeout_o[g]),
      .cause_o     (w_cause[g]),
      .rst_req_o   (rst_req_o[g])
    );
    assign cause_o[g*3 +: 3] = w_cause[g];
  end

  assign irq_o = |timeout_o;

endmodule

// File: tb/tb_slv_guard_watchdog.sv
// Bench for slv_guard_watchdog: constant-expectation vector table, hand-written
// multi-cycle sequences and a randomized phase, all shadowed cycle by cycle
// by a behavioural model of the port rules.
module tb_slv_guard_watchdog;

  localparam int NS  = 2;
  localparam int CW  = 10;
  localparam int MT  = 8;
  localparam int W2  = NS * 2;
  localparam int W3  = NS * 3;
  localparam int SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic [W2-1:0]   aw, b, ar;
  logic [W3-1:0]   w, r;
  logic [CW-1:0]   bud [5];
  logic [NS-1:0]   clr, rst_stat;
  logic [NS-1:0]   timeout, rst_req;
  logic [W3-1:0]   cause;
  logic            irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: outstanding counts (AW->W, W->B, AR->R), stall ages, phase, cause.
  int m_pend  [NS][3];
  int m_age   [NS][5];
  int m_phase [NS];   // 0 monitoring, 1 faulted, 2 requesting reset, 3 in reset, 4 halted
  int m_cause [NS];

  typedef struct packed {
    logic [1:0] aw;
    logic [2:0] w;
    logic [1:0] b;
    logic [1:0] ar;
    logic [2:0] r;
    logic       exp_to;
    logic [2:0] exp_cause;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  slv_guard_watchdog #(.NumSub(NS), .CntWidth(CW), .MaxTxns(MT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .guard_ena_i (ena),
    .aw_hs_i     (aw),
    .w_hs_i      (w),
    .b_hs_i      (b),
    .ar_hs_i     (ar),
    .r_hs_i      (r),
    .budget_aw_i (bud[0]),
    .budget_w_i  (bud[1]),
    .budget_b_i  (bud[2]),
    .budget_ar_i (bud[3]),
    .budget_r_i  (bud[4]),
    .clr_i       (clr),
    .rst_stat_i  (rst_stat),
    .timeout_o   (timeout),
    .cause_o     (cause),
    .rst_req_o   (rst_req),
    .irq_o       (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the port rules to the inputs present at this clock edge.
  task automatic model_step();
    for (int p = 0; p < NS; p++) begin
      if (rst) begin
        for (int i = 0; i < 3; i++) m_pend[p][i] = 0;
        for (int k = 0; k < 5; k++) m_age[p][k] = 0;
        m_phase[p] = 0;
        m_cause[p] = 0;
      end else begin
        bit aw_hs  = aw[2*p+1] && aw[2*p];
        bit w_any  = w[3*p+2] && w[3*p+1];
        bit w_last = w_any && w[3*p];
        bit b_hs   = b[2*p+1] && b[2*p];
        bit ar_hs  = ar[2*p+1] && ar[2*p];
        bit r_any  = r[3*p+2] && r[3*p+1];
        bit r_last = r_any && r[3*p];
        bit inc [3];
        bit dec [3];
        bit run [5];
        int best = 0;
        inc[0] = aw_hs;  dec[0] = w_last;
        inc[1] = w_last; dec[1] = b_hs;
        inc[2] = ar_hs;  dec[2] = r_last;
        run[0] = aw[2*p+1] && !aw[2*p];
        run[1] = (m_pend[p][0] > 0) && !w_any;
        run[2] = (m_pend[p][1] > 0) && !b_hs;
        run[3] = ar[2*p+1] && !ar[2*p];
        run[4] = (m_pend[p][2] > 0) && !r_any;
        for (int k = 0; k < 5; k++)
          if (run[k] && int'(bud[k]) != 0 && m_age[p][k] == int'(bud[k])) best = k + 1;
        if ((w_last && m_pend[p][0] == 0 && !aw_hs) || (b_hs && m_pend[p][1] == 0) ||
            (r_last && m_pend[p][2] == 0 && !ar_hs)) best = 6;
        for (int i = 0; i < 3; i++)
          if (inc[i] && !dec[i] && m_pend[p][i] == MT) best = 7;
        if (m_phase[p] == 0) begin
          for (int i = 0; i < 3; i++) begin
            if (inc[i] && !dec[i]) m_pend[p][i] = (m_pend[p][i] < MT) ? m_pend[p][i] + 1 : MT;
            else if (dec[i] && !inc[i]) m_pend[p][i] = (m_pend[p][i] > 0) ? m_pend[p][i] - 1 : 0;
          end
        end
        for (int k = 0; k < 5; k++) begin
          if (!ena || int'(bud[k]) == 0) m_age[p][k] = 0;
          else if (m_phase[p] == 0) m_age[p][k] = run[k] ? ((m_age[p][k] < SAT) ? m_age[p][k] + 1 : SAT) : 0;
        end
        case (m_phase[p])
          0: if (ena && best > 0) begin m_phase[p] = 1; m_cause[p] = best; end
          1: m_phase[p] = 2;
          2: if (rst_stat[p]) m_phase[p] = 3;
          3: if (!rst_stat[p]) begin
               m_phase[p] = 4;
               for (int i = 0; i < 3; i++) m_pend[p][i] = 0;
               for (int k = 0; k < 5; k++) m_age[p][k] = 0;
             end
          4: if (clr[p]) begin m_phase[p] = 0; m_cause[p] = 0; end
          default: m_phase[p] = 0;
        endcase
      end
    end
  endtask

  task automatic check_model();
    int any = 0;
    for (int p = 0; p < NS; p++) begin
      chk($sformatf("model_timeout[%0d]", p), timeout[p], (m_phase[p] != 0) ? 1 : 0);
      chk($sformatf("model_cause[%0d]", p), cause[3*p +: 3], m_cause[p]);
      chk($sformatf("model_rst_req[%0d]", p), rst_req[p], (m_phase[p] == 2) ? 1 : 0);
      if (m_phase[p] != 0) any = 1;
    end
    chk("model_irq", irq, any);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle();
    aw = '0; w = '0; b = '0; ar = '0; r = '0;
  endtask

  task automatic do_reset();
    idle();
    clr = '0; rst_stat = '0; ena = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic zero_bud();
    for (int k = 0; k < 5; k++) bud[k] = '0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; clr = '0; rst_stat = '0;
    idle(); zero_bud();

    // Single-cycle port-0 patterns from a clean state, all budgets disabled.
    tbl[0] = '{2'b00, 3'b111, 2'b00, 2'b00, 3'b000, 1'b1, 3'd6}; // W last, no AW
    tbl[1] = '{2'b11, 3'b111, 2'b00, 2'b00, 3'b000, 1'b0, 3'd0}; // W last with AW
    tbl[2] = '{2'b00, 3'b000, 2'b11, 2'b00, 3'b000, 1'b1, 3'd6}; // B with nothing pending
    tbl[3] = '{2'b00, 3'b000, 2'b00, 2'b00, 3'b111, 1'b1, 3'd6}; // R last, no AR
    tbl[4] = '{2'b00, 3'b000, 2'b00, 2'b11, 3'b111, 1'b0, 3'd0}; // R last with AR
    tbl[5] = '{2'b11, 3'b000, 2'b00, 2'b00, 3'b000, 1'b0, 3'd0}; // AW only
    tbl[6] = '{2'b00, 3'b110, 2'b00, 2'b00, 3'b000, 1'b0, 3'd0}; // W beat, not last
    tbl[7] = '{2'b00, 3'b000, 2'b00, 2'b10, 3'b000, 1'b0, 3'd0}; // AR stall, budget off
    tbl[8] = '{2'b11, 3'b111, 2'b11, 2'b00, 3'b000, 1'b1, 3'd6}; // B racing its own W last
    tbl[9] = '{2'b00, 3'b101, 2'b00, 2'b00, 3'b000, 1'b0, 3'd0}; // W valid without ready

    do_reset();
    chk("reset_timeout", timeout, 0);
    chk("reset_cause", cause, 0);
    chk("reset_rst_req", rst_req, 0);
    chk("reset_irq", irq, 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      aw = {2'b00, tbl[i].aw}; w = {3'b000, tbl[i].w}; b = {2'b00, tbl[i].b};
      ar = {2'b00, tbl[i].ar}; r = {3'b000, tbl[i].r};
      tick();
      idle();
      chk($sformatf("tbl%0d_timeout0", i), timeout[0], tbl[i].exp_to);
      chk($sformatf("tbl%0d_cause0", i), cause[2:0], tbl[i].exp_cause);
      chk($sformatf("tbl%0d_port1", i), timeout[1], 0);
    end

    // AW stall against budget 5: fault visible after the 6th edge; rst_i aborts the request.
    do_reset(); bud[0] = 10'd5;
    aw = 4'b0010;
    repeat (5) tick();
    chk("aw_early", timeout[0], 0);
    tick();
    chk("aw_timeout", timeout[0], 1);
    chk("aw_cause", cause[2:0], 1);
    chk("aw_irq", irq, 1);
    chk("aw_port1", timeout[1], 0);
    idle(); tick();
    chk("aw_rst_req", rst_req[0], 1);
    tick();
    chk("aw_rst_req_hold", rst_req[0], 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("aw_abort_rst_req", rst_req[0], 0);
    chk("aw_abort_timeout", timeout[0], 0);
    zero_bud();

    // W missing after AW, budget 3; full reset handshake and software release.
    do_reset(); bud[1] = 10'd3;
    aw = 4'b0011; tick(); idle();
    repeat (3) tick();
    chk("w_early", timeout[0], 0);
    tick();
    chk("w_timeout", timeout[0], 1);
    chk("w_cause", cause[2:0], 2);
    clr = 2'b01; tick(); tick(); clr = '0;
    chk("w_clr_ignored", timeout[0], 1);
    chk("w_rst_req", rst_req[0], 1);
    repeat (3) tick();
    chk("w_rst_req_hold", rst_req[0], 1);
    rst_stat = 2'b01; tick();
    chk("w_rst_req_drop", rst_req[0], 0);
    chk("w_wait_timeout", timeout[0], 1);
    rst_stat = '0; tick();
    chk("w_halt_cause", cause[2:0], 2);
    clr = 2'b01; tick(); clr = '0;
    chk("w_cleared_to", timeout[0], 0);
    chk("w_cleared_cause", cause[2:0], 0);
    chk("w_cleared_irq", irq, 0);
    w = 6'b000111; tick(); idle();
    chk("w_counters_restart", cause[2:0], 6);
    zero_bud();

    // Outstanding-read overflow on the 9th AR, then a balanced 8/8 exchange.
    do_reset();
    ar = 4'b0011;
    repeat (8) tick();
    chk("ovf_8_ok", timeout[0], 0);
    tick(); idle();
    chk("ovf_9th", cause[2:0], 7);
    do_reset();
    ar = 4'b0011; repeat (8) tick();
    ar = '0; r = 6'b000111; repeat (8) tick();
    chk("bal_no_fault", timeout[0], 0);
    tick(); idle();
    chk("bal_pend_zero", cause[2:0], 6);

    // Missing B with its check disabled for 1000 cycles, then enabled at budget 4.
    do_reset();
    aw = 4'b0011; tick();
    aw = '0; w = 6'b000111; tick(); idle();
    repeat (1000) tick();
    chk("b_disabled", timeout[0], 0);
    bud[2] = 10'd4;
    repeat (4) tick();
    chk("b_early", timeout[0], 0);
    tick();
    chk("b_timeout", cause[2:0], 3);
    zero_bud();

    // AR stall and R timeout hit together: R has the higher code.
    do_reset(); bud[3] = 10'd3; bud[4] = 10'd3;
    ar = 4'b0011; tick();
    ar = 4'b0010;
    repeat (3) tick();
    chk("arr_early", timeout[0], 0);
    tick(); idle();
    chk("arr_cause", cause[2:0], 5);
    zero_bud();

    // Disabled guard latches nothing; dropping enable restarts a stall timer.
    do_reset(); ena = 1'b0;
    w = 6'b000111; tick(); idle();
    chk("ena_off_no_fault", timeout[0], 0);
    ena = 1'b1; bud[0] = 10'd3;
    aw = 4'b0010; tick(); tick();
    ena = 1'b0; tick(); ena = 1'b1;
    repeat (3) tick();
    chk("ena_restart_early", timeout[0], 0);
    tick(); idle();
    chk("ena_restart_cause", cause[2:0], 1);
    zero_bud();

    // Randomized traffic on both ports against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        for (int k = 0; k < 5; k++)
          bud[k] = ($urandom_range(0, 3) == 0) ? 10'd0 : CW'($urandom_range(1, 12));
      aw = W2'($urandom); b = W2'($urandom); ar = W2'($urandom);
      w = W3'($urandom); r = W3'($urandom);
      ena = ($urandom_range(0, 15) != 0);
      rst_stat = NS'($urandom);
      clr = NS'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
